// File: rtl/fetch_ifid_stage_pkg.sv
// Shared constants for the fetch / IF-ID slice of the ARM-subset pipeline:
// bubble word, PC step, instruction field positions and the fetch FSM encoding.
package fetch_ifid_stage_pkg;

  localparam int          IFID_PC_INC   = 4;
  localparam logic [31:0] IFID_NOP_WORD = 32'h0000_0000;

  localparam int COND_HI  = 31;
  localparam int RN_HI    = 19;
  localparam int RD_HI    = 15;
  localparam int RM_HI    = 3;
  localparam int IMM12_HI = 11;
  localparam int OFF24_HI = 23;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_ifid_stage_ifid.sv
// IF/ID pipeline register: flush beats load, otherwise holds. Decode fields
// are plain slices of the latched word.
module ifid_reg
  import fetch_ifid_stage_pkg::*;
#(
  parameter int                 PC_W     = 8,
  parameter int                 INSTR_W  = 32,
  parameter logic [INSTR_W-1:0] NOP_WORD = IFID_NOP_WORD
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic               i_flush,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [PC_W-1:0]    i_next_pc,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_next_pc,
  output logic               o_valid,
  output logic [3:0]         o_cond,
  output logic [3:0]         o_rn,
  output logic [3:0]         o_rd,
  output logic [3:0]         o_rm,
  output logic [11:0]        o_imm12,
  output logic [23:0]        o_off24
);

  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_next_pc;
  logic               r_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_instr   <= NOP_WORD;
      r_next_pc <= '0;
      r_valid   <= 1'b0;
    end else if (i_flush) begin
      r_instr   <= NOP_WORD;
      r_next_pc <= '0;
      r_valid   <= 1'b0;
    end else if (i_load) begin
      r_instr   <= i_instr;
      r_next_pc <= i_next_pc;
      r_valid   <= 1'b1;
    end
  end

  assign o_instr   = r_instr;
  assign o_next_pc = r_next_pc;
  assign o_valid   = r_valid;
  assign o_cond    = r_instr[COND_HI -: 4];
  assign o_rn      = r_instr[RN_HI -: 4];
  assign o_rd      = r_instr[RD_HI -: 4];
  assign o_rm      = r_instr[RM_HI -: 4];
  assign o_imm12   = r_instr[IMM12_HI -: 12];
  assign o_off24   = r_instr[OFF24_HI -: 24];

endmodule

// File: rtl/fetch_ifid_stage.sv
// Instruction-fetch front end: PC register, next-PC select (branch > stall >
// advance), one-cycle BOOT hold after reset, and fetch/flush counters.
module fetch_ifid_stage
  import fetch_ifid_stage_pkg::*;
#(
  parameter int                 PC_W     = 8,
  parameter int                 INSTR_W  = 32,
  parameter int                 PC_INC   = IFID_PC_INC,
  parameter logic [PC_W-1:0]    RESET_PC = '0,
  parameter logic [INSTR_W-1:0] NOP_WORD = IFID_NOP_WORD
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_stall,
  input  logic               i_branch_taken,
  input  logic [PC_W-1:0]    i_branch_target,
  input  logic [INSTR_W-1:0] i_rom_data,
  output logic [PC_W-1:0]    o_rom_addr,
  output logic [INSTR_W-1:0] o_ifid_instr,
  output logic [PC_W-1:0]    o_ifid_next_pc,
  output logic               o_ifid_valid,
  output logic [3:0]         o_instr_i31_i28,
  output logic [3:0]         o_instr_i19_i16,
  output logic [3:0]         o_instr_i15_i12,
  output logic [3:0]         o_instr_i3_i0,
  output logic [11:0]        o_instr_i11_i0,
  output logic [23:0]        o_instr_i23_i0,
  output logic [15:0]        o_fetch_cnt,
  output logic [15:0]        o_flush_cnt
);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  fetch_state_e    r_state;
  fetch_state_e    w_state_next;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_fetch_cnt;
  logic [15:0]     r_flush_cnt;
  logic            w_run;
  logic            w_flush;
  logic            w_load;
  logic [PC_W-1:0] w_pc_seq;
  logic [PC_W-1:0] w_target_aligned;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= BOOT;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      BOOT:    w_state_next = RUN;
      RUN:     w_state_next = RUN;
      default: w_state_next = BOOT;
    endcase
  end

  // BOOT ignores every input, so all controls are gated by RUN.
  assign w_run            = (r_state == RUN);
  assign w_flush          = w_run & i_branch_taken;
  assign w_load           = w_run & ~i_branch_taken & ~i_stall;
  assign w_pc_seq         = r_pc + PC_W'(PC_INC);
  assign w_target_aligned = {i_branch_target[PC_W-1:2], 2'b00};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc        <= RESET_PC;
      r_fetch_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (w_flush) begin
      r_pc <= w_target_aligned;
      if (r_flush_cnt != CNT_MAX) r_flush_cnt <= r_flush_cnt + 16'd1;
    end else if (w_load) begin
      r_pc <= w_pc_seq;
      if (r_fetch_cnt != CNT_MAX) r_fetch_cnt <= r_fetch_cnt + 16'd1;
    end
  end

  ifid_reg #(
    .PC_W     (PC_W),
    .INSTR_W  (INSTR_W),
    .NOP_WORD (NOP_WORD)
  ) u_ifid (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (w_load),
    .i_flush   (w_flush),
    .i_instr   (i_rom_data),
    .i_next_pc (w_pc_seq),
    .o_instr   (o_ifid_instr),
    .o_next_pc (o_ifid_next_pc),
    .o_valid   (o_ifid_valid),
    .o_cond    (o_instr_i31_i28),
    .o_rn      (o_instr_i19_i16),
    .o_rd      (o_instr_i15_i12),
    .o_rm      (o_instr_i3_i0),
    .o_imm12   (o_instr_i11_i0),
    .o_off24   (o_instr_i23_i0)
  );

  assign o_rom_addr  = r_pc;
  assign o_fetch_cnt = r_fetch_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Directed bench for fetch_ifid_stage; ROM word at byte address A is
// 32'hE000_0000 + A/4 unless an override word is forced onto the bus.
module tb_fetch_ifid_stage;

  logic        clk = 1'b0;
  logic        rstN;
  logic        stall;
  logic        branchTaken;
  logic [7:0]  branchTarget;
  logic [31:0] romData;
  logic [7:0]  romAddr;
  logic [31:0] ifidInstr;
  logic [7:0]  ifidNextPc;
  logic        ifidValid;
  logic [3:0]  fCond, fRn, fRd, fRm;
  logic [11:0] fImm12;
  logic [23:0] fOff24;
  logic [15:0] fetchCnt;
  logic [15:0] flushCnt;

  logic        romOverrideEn  = 1'b0;
  logic [31:0] romOverrideVal = 32'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign romData = romOverrideEn ? romOverrideVal : (32'hE000_0000 + 32'(romAddr >> 2));

  fetch_ifid_stage dut (
    .i_clk           (clk),
    .i_rst_n         (rstN),
    .i_stall         (stall),
    .i_branch_taken  (branchTaken),
    .i_branch_target (branchTarget),
    .i_rom_data      (romData),
    .o_rom_addr      (romAddr),
    .o_ifid_instr    (ifidInstr),
    .o_ifid_next_pc  (ifidNextPc),
    .o_ifid_valid    (ifidValid),
    .o_instr_i31_i28 (fCond),
    .o_instr_i19_i16 (fRn),
    .o_instr_i15_i12 (fRd),
    .o_instr_i3_i0   (fRm),
    .o_instr_i11_i0  (fImm12),
    .o_instr_i23_i0  (fOff24),
    .o_fetch_cnt     (fetchCnt),
    .o_flush_cnt     (flushCnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset state, then BOOT cycle with a branch request that must be ignored.
  task automatic test_reset();
    rstN = 1'b0; stall = 1'b0; branchTaken = 1'b0; branchTarget = 8'h00;
    tick(); tick();
    checks++; if (romAddr !== 8'h00) begin errors++; $display("[TB] FAIL reset_pc got %h exp 00", romAddr); end
    checks++; if (ifidInstr !== 32'h0 || ifidValid !== 1'b0 || ifidNextPc !== 8'h00) begin errors++; $display("[TB] FAIL reset_ifid got %h/%b/%h exp 0/0/0", ifidInstr, ifidValid, ifidNextPc); end
    checks++; if (fetchCnt !== 16'd0 || flushCnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_cnt got %0d/%0d exp 0/0", fetchCnt, flushCnt); end
    checks++; if ({fCond, fRn, fRd, fRm, fImm12, fOff24} !== 52'h0) begin errors++; $display("[TB] FAIL reset_fields got nonzero"); end
    rstN = 1'b1; branchTaken = 1'b1; branchTarget = 8'h40;
    tick();
    branchTaken = 1'b0;
    checks++; if (romAddr !== 8'h00 || flushCnt !== 16'd0 || fetchCnt !== 16'd0) begin errors++; $display("[TB] FAIL boot_hold got pc %h flush %0d fetch %0d exp 00/0/0", romAddr, flushCnt, fetchCnt); end
  endtask

  task automatic test_sequential();
    for (int k = 1; k <= 2; k++) begin
      tick();
      checks++; if (romAddr !== 8'(4*k)) begin errors++; $display("[TB] FAIL seq_pc%0d got %h exp %h", k, romAddr, 8'(4*k)); end
      checks++; if (ifidInstr !== 32'hE000_0000 + 32'(k-1) || ifidValid !== 1'b1) begin errors++; $display("[TB] FAIL seq_instr%0d got %h/%b exp %h/1", k, ifidInstr, ifidValid, 32'hE000_0000 + 32'(k-1)); end
      checks++; if (ifidNextPc !== 8'(4*k) || fetchCnt !== 16'(k)) begin errors++; $display("[TB] FAIL seq_npc%0d got %h/%0d exp %h/%0d", k, ifidNextPc, fetchCnt, 8'(4*k), k); end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (romAddr !== 8'h08 || ifidInstr !== 32'hE000_0001 || fetchCnt !== 16'd2) begin errors++; $display("[TB] FAIL stall_hold%0d got %h/%h/%0d exp 08/E0000001/2", k, romAddr, ifidInstr, fetchCnt); end
    end
    stall = 1'b0;
    tick();
    checks++; if (romAddr !== 8'h0C || ifidInstr !== 32'hE000_0002 || fetchCnt !== 16'd3) begin errors++; $display("[TB] FAIL stall_resume got %h/%h/%0d exp 0C/E0000002/3", romAddr, ifidInstr, fetchCnt); end
    tick();
    checks++; if (romAddr !== 8'h10 || ifidNextPc !== 8'h10) begin errors++; $display("[TB] FAIL pre_branch got %h/%h exp 10/10", romAddr, ifidNextPc); end
  endtask

  task automatic test_branch_stall();
    branchTaken = 1'b1; stall = 1'b1; branchTarget = 8'h40;
    tick();
    branchTaken = 1'b0; stall = 1'b0;
    checks++; if (romAddr !== 8'h40 || flushCnt !== 16'd1 || fetchCnt !== 16'd4) begin errors++; $display("[TB] FAIL br_pc got %h/%0d/%0d exp 40/1/4", romAddr, flushCnt, fetchCnt); end
    checks++; if (ifidInstr !== 32'h0 || ifidValid !== 1'b0 || ifidNextPc !== 8'h00) begin errors++; $display("[TB] FAIL br_bubble got %h/%b/%h exp 0/0/0", ifidInstr, ifidValid, ifidNextPc); end
    tick();
    checks++; if (ifidInstr !== 32'hE000_0010 || ifidValid !== 1'b1 || ifidNextPc !== 8'h44 || fetchCnt !== 16'd5) begin errors++; $display("[TB] FAIL br_target got %h/%b/%h/%0d exp E0000010/1/44/5", ifidInstr, ifidValid, ifidNextPc, fetchCnt); end
  endtask

  task automatic test_misaligned();
    branchTaken = 1'b1; branchTarget = 8'h23;
    tick();
    branchTaken = 1'b0;
    checks++; if (romAddr !== 8'h20 || flushCnt !== 16'd2) begin errors++; $display("[TB] FAIL misalign got %h/%0d exp 20/2", romAddr, flushCnt); end
    tick();
    checks++; if (ifidInstr !== 32'hE000_0008 || romAddr !== 8'h24) begin errors++; $display("[TB] FAIL misalign_fetch got %h/%h exp E0000008/24", ifidInstr, romAddr); end
  endtask

  task automatic test_wrap();
    branchTaken = 1'b1; branchTarget = 8'hFC;
    tick();
    branchTaken = 1'b0;
    tick();
    checks++; if (romAddr !== 8'h00 || ifidNextPc !== 8'h00 || ifidInstr !== 32'hE000_003F) begin errors++; $display("[TB] FAIL wrap got %h/%h/%h exp 00/00/E000003F", romAddr, ifidNextPc, ifidInstr); end
    checks++; if (fetchCnt !== 16'd7 || flushCnt !== 16'd3) begin errors++; $display("[TB] FAIL wrap_cnt got %0d/%0d exp 7/3", fetchCnt, flushCnt); end
  endtask

  task automatic test_fields();
    romOverrideEn = 1'b1; romOverrideVal = 32'hA5B6_C7D8;
    tick();
    checks++; if (fCond !== 4'hA || fRn !== 4'h6 || fRd !== 4'hC || fRm !== 4'h8) begin errors++; $display("[TB] FAIL fields4 got %h %h %h %h exp A 6 C 8", fCond, fRn, fRd, fRm); end
    checks++; if (fImm12 !== 12'h7D8 || fOff24 !== 24'hB6C7D8) begin errors++; $display("[TB] FAIL fields_wide got %h %h exp 7D8 B6C7D8", fImm12, fOff24); end
    romOverrideVal = 32'h0;
    tick();
    checks++; if (ifidInstr !== 32'h0 || ifidValid !== 1'b1 || fetchCnt !== 16'd9) begin errors++; $display("[TB] FAIL zero_word got %h/%b/%0d exp 0/1/9", ifidInstr, ifidValid, fetchCnt); end
    romOverrideEn = 1'b0;
  endtask

  task automatic test_midrun_reset();
    branchTaken = 1'b1; branchTarget = 8'h30;
    tick();
    branchTaken = 1'b0;
    checks++; if (romAddr !== 8'h30 || flushCnt !== 16'd4) begin errors++; $display("[TB] FAIL pre_reset got %h/%0d exp 30/4", romAddr, flushCnt); end
    #2 rstN = 1'b0;
    #1;
    checks++; if (romAddr !== 8'h00 || ifidInstr !== 32'h0 || ifidValid !== 1'b0 || fetchCnt !== 16'd0 || flushCnt !== 16'd0) begin errors++; $display("[TB] FAIL async_reset got %h/%h/%b/%0d/%0d exp 00/0/0/0/0", romAddr, ifidInstr, ifidValid, fetchCnt, flushCnt); end
    #2 rstN = 1'b1;
    tick();
    checks++; if (romAddr !== 8'h00 || fetchCnt !== 16'd0 || ifidValid !== 1'b0) begin errors++; $display("[TB] FAIL reboot_hold got %h/%0d/%b exp 00/0/0", romAddr, fetchCnt, ifidValid); end
    tick();
    checks++; if (romAddr !== 8'h04 || ifidInstr !== 32'hE000_0000 || fetchCnt !== 16'd1) begin errors++; $display("[TB] FAIL reboot_run got %h/%h/%0d exp 04/E0000000/1", romAddr, ifidInstr, fetchCnt); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_stall();
    test_misaligned();
    test_wrap();
    test_fields();
    test_midrun_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ifid_stage.md
Name: fetch_ifid_stage

Overview:
- Instruction-fetch front end of the 5-stage ARM-subset pipeline: holds the PC, drives the instruction ROM address, selects the next PC (sequential, branch target, or hold), and registers the fetched word into the IF/ID pipeline register.
- Feeds the ID stage (ControlUnit, register-file address fields, condition handler) with the latched instruction, its decode fields and Next_PC.
- Consumes branch_taken/target from the condition handler and stall from the hazard logic.

Parameters:
- PC_W, 8, width of PC and ROM byte address.
- INSTR_W, 32, instruction word width.
- PC_INC, 4, sequential PC increment (bytes).
- RESET_PC, 0, PC value loaded at reset.
- NOP_WORD, 32'h0000_0000, bubble word written into IF/ID on reset and flush.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- stall  input  1  hold PC and IF/ID (load-use hazard).
- branch_taken  input  1  from condition handler; redirect fetch and flush IF/ID.
- branch_target  input  PC_W  target address TA.
- rom_data  input  INSTR_W  instruction word returned combinationally by ROM for rom_addr.
- rom_addr  output  PC_W  current PC to ROM.
- ifid_instr  output  INSTR_W  latched instruction.
- ifid_next_pc  output  PC_W  PC+PC_INC of latched instruction.
- ifid_valid  output  1  1 = ifid_instr is a real fetch, 0 = bubble.
- instr_i31_i28, instr_i19_i16, instr_i15_i12, instr_i3_i0  output  4 each  fields of ifid_instr.
- instr_i11_i0  output  12  field of ifid_instr.
- instr_i23_i0  output  24  branch offset field of ifid_instr.
- fetch_cnt  output  16  count of valid words loaded into IF/ID.
- flush_cnt  output  16  count of branch flushes.

Behaviour:
- Reset (reset=0, async): PC=RESET_PC, ifid_instr=NOP_WORD, ifid_next_pc=0, ifid_valid=0, both counters 0, FSM=BOOT. Field outputs are pure slices of ifid_instr, so all are 0.
- FSM states and transitions:
  - BOOT: one cycle after reset deasserts. PC and IF/ID hold; inputs are ignored, including branch_taken. Always goes to RUN.
  - RUN: normal operation. Exits only on reset.
- RUN, per rising edge, priority branch_taken > stall > advance:
  - branch_taken=1: PC <= {branch_target[PC_W-1:2], 2'b00}; misaligned targets are silently aligned. IF/ID <= NOP_WORD, ifid_valid <= 0, ifid_next_pc <= 0, flush_cnt++. Overrides a simultaneous stall.
  - stall=1: PC, IF/ID and fetch_cnt hold.
  - advance: ifid_instr <= rom_data, ifid_next_pc <= PC+PC_INC, ifid_valid <= 1, PC <= PC+PC_INC, fetch_cnt++.
- Latency: a word at PC appears on ifid_instr one edge after rom_addr=PC, provided there is no stall and no flush.
- Arithmetic is modulo 2^PC_W; PC 0xFC advances to 0x00 with no flag.
- Counters saturate at 16'hFFFF and do not wrap.
- rom_addr equals the PC register directly; there is no combinational path from inputs to rom_addr.
- An instruction with all-zero encoding loaded by advance is still valid=1; the ID stage decides whether it is a NOP.
- Reset asserted mid-operation clears everything immediately and forces BOOT again.

Decomposition:
- Shared pipeline package holds:
  - NOP_WORD and the PC_INC constant;
  - field-slice bit positions (COND_HI=31, RN_HI=19, RD_HI=15, RM_HI=3);
  - the FSM state encoding (BOOT=1'b0, RUN=1'b1).
- One natural sub-module: ifid_reg, the IF/ID register with load/flush/hold controls and field slicing. PC/next-PC logic, FSM and counters stay in the top module.

Test Plan:
- Reset release, no stall/branch, ROM[i] = 32'hE000_0000+i: BOOT cycle holds PC=0; then rom_addr 0,4,8,…; ifid_instr follows one edge later; ifid_next_pc=4,8,…; fetch_cnt increments each edge.
- Stall high 2 cycles at PC=0x08: PC stays 0x08, ifid_instr stays word@0x04, fetch_cnt frozen; resumes with word@0x08 on release.
- branch_taken=1 with stall=1, target 0x40 at PC=0x10: next edge PC=0x40, ifid_instr=0, ifid_valid=0, flush_cnt=1; following edge ifid_instr=word@0x40.
- Misaligned target 0x23: PC becomes 0x20.
- PC at 0xFC advancing: next PC 0x00, ifid_next_pc=0x00; branch_taken during BOOT is ignored.
- Reset pulled low mid-run at PC=0x30: outputs immediately PC=0, ifid_instr=0, valid=0, counters 0; one BOOT cycle after release.
